loba_pipe_mult: RTL and testbench
=================================

// Module: loba_pipe_mult
// PURPOSE
//  Pipelined, handshaked LOBA approximate multiplier (leading-one bit-slice).
//  Per-transaction runtime selection of accuracy (1-4 partial products) and signedness.
//  Sits between valid/ready datapath stages in accelerators; 3-stage pipeline, full throughput.
// PARAMETERS
//  N  16  operand width in bits (N >= 2*K)
//  K  4   bit-slice width per segment (K >= 2)
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      operands/mode valid
//  in_ready   out  1      block accepts input this cycle
//  a          in   N      operand A
//  b          in   N      operand B
//  mode       in   2      partial-product count minus 1 (0:HH, 1:+HL, 2:+LH, 3:+LL)
//  is_signed  in   1      1: operands are two's complement; 0: unsigned
//  out_valid  out  1      result valid
//  out_ready  in   1      downstream accepts result
//  r          out  2N     product, two's complement if is_signed
// BEHAVIOUR
//  Reset: out_valid=0, r=0, all stage valids=0; in_ready=1 once rst_n is high. Async assert, sync release.
//  Transfer on in_valid&in_ready (input) and out_valid&out_ready (output).
//  Global stall: in_ready = ~out_valid | out_ready; all stages advance when in_ready=1.
//  Latency exactly 3 cycles with no stall; one result per cycle sustained; results in input order.
//  Bubbles propagate as invalid stages; out_valid/r hold stable while out_valid & ~out_ready.
//  mode and is_signed are captured with their operands and travel down the pipeline.
//  S1: magnitude |X| (N bits; -2^(N-1) -> 2^(N-1)); sign = is_signed & (a[N-1]^b[N-1]).
//    msb(v) = index of highest set bit; kh = max(msb(|X|), K-1); Xh = |X|[kh -: K].
//    L = |X| with bits [N-1 : kh-K+1] cleared; kl = max(msb(L), K-1); Xl = L[kl -: K].
//    |X| = 0 -> Xh = Xl = 0, kh = kl = K-1; L = 0 -> Xl = 0, kl = K-1.
//  S2: PP_HH = (Ah*Bh) << (kha+khb-2(K-1)); PP_HL = (Ah*Bl) << (kha+klb-2(K-1));
//    PP_LH = (Al*Bh) << (kla+khb-2(K-1)); PP_LL = (Al*Bl) << (kla+klb-2(K-1)).
//    Shift amounts are never negative; all terms are 2N bits wide.
//  S3: sum of the terms enabled by mode (mode 0: HH; 1: +HL; 2: +HL+LH; 3: all four).
//    Sum modulo 2^(2N). If sign, r = (~sum + 1) mod 2^(2N). Zero magnitude -> r = 0 regardless of sign.
//  Result is <= exact |a*b| for all modes; mode 3 is exact when each operand has <= 2K significant bits.
//  A transaction accepted in the same cycle another is released keeps full throughput.
//  Reset mid-operation: all in-flight transactions are discarded and none appear after release.
// TESTING (N=16, K=4)
//  1) a=200, b=100, is_signed=0, mode 0/1/2/3 -> r = 18432 / 19200 / 19968 / 20000, each 3 cycles after accept.
//  2) a=16'hFF38 (-200), b=100, is_signed=1, mode=3 -> r = 32'hFFFFB1E0 (-20000);
//     same operands with is_signed=0 -> unsigned LOBA3 product of 65336*100.
//  3) a=5, b=7, mode=0 -> r=35 (exact, kh clamped to K-1); a=0, b=16'h8000, is_signed=1 -> r=0.
//  4) Back-to-back: 8 inputs on consecutive cycles, out_ready=1 -> 8 results on consecutive cycles, in order.
//  5) Stall: fill the pipe, drop out_ready for 5 cycles -> in_ready=0, r/out_valid held;
//     on release, no loss or duplication.
//  6) Assert rst_n low with 3 in flight -> out_valid=0 immediately, r=0; after release, no stale outputs.

Source files
------------

// File: rtl/loba_pipe_mult_if.sv
// Valid/ready bus for the LOBA pipelined multiplier: operand side in, product side out.
interface loba_pipe_mult_if #(
    parameter int N = 16
);
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic [1:0]     mode;
    logic           is_signed;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] r;

    modport master (
        output in_valid, a, b, mode, is_signed, out_ready,
        input  in_ready, out_valid, r
    );

    modport slave (
        input  in_valid, a, b, mode, is_signed, out_ready,
        output in_ready, out_valid, r
    );
endinterface

// File: rtl/loba_pipe_mult.sv
// LOBA approximate multiplier: leading-one K-bit segments, 1-4 partial products,
// 3-stage valid/ready pipeline with a single global stall.
module loba_seg #(
    parameter int N  = 16,
    parameter int K  = 4,
    parameter int KW = $clog2(N)
) (
    input  logic [N-1:0]  v,
    output logic [K-1:0]  hi,
    output logic [K-1:0]  lo,
    output logic [KW-1:0] kh,
    output logic [KW-1:0] kl
);
    // Leading-one position clamped to K-1; bits below K never change the result.
    function automatic logic [KW-1:0] lead(input logic [N-1:0] x);
        lead = KW'(K - 1);
        for (int i = K; i < N; i++)
            if (x[i]) lead = KW'(i);
    endfunction

    logic [KW-1:0] sh_h, sh_l;
    logic [N-1:0]  rest;

    always_comb begin
        kh   = lead(v);
        sh_h = kh - KW'(K - 1);
        hi   = K'(v >> sh_h);
        rest = v & ~({N{1'b1}} << sh_h);
        kl   = lead(rest);
        sh_l = kl - KW'(K - 1);
        lo   = K'(rest >> sh_l);
    end
endmodule

module loba_pipe_mult #(
    parameter int N = 16,
    parameter int K = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    loba_pipe_mult_if.slave  bus
);
    localparam int STAGES = 3;
    localparam int KW     = $clog2(N);
    localparam int W      = 2 * N;
    localparam int SHW    = $clog2(W) + 1;

    typedef struct packed {
        logic [1:0][K-1:0]  hi;
        logic [1:0][K-1:0]  lo;
        logic [1:0][KW-1:0] kh;
        logic [1:0][KW-1:0] kl;
        logic               sign;
        logic [1:0]         mode;
    } s1_t;

    typedef struct packed {
        logic [3:0][W-1:0] pp;
        logic              sign;
        logic [1:0]        mode;
    } s2_t;

    logic               en;
    logic [STAGES:1]    vld_q;
    logic [STAGES:0]    vld_pipe;
    logic [1:0][N-1:0]  opnd, mag;
    logic [1:0][K-1:0]  hi_d, lo_d;
    logic [1:0][KW-1:0] kh_d, kl_d;
    s1_t                s1_d, s1_q;
    s2_t                s2_d, s2_q;
    logic [W-1:0]       sum, r_d, r_q;

    assign en            = ~vld_q[STAGES] | bus.out_ready;
    assign bus.in_ready  = en;
    assign bus.out_valid = vld_q[STAGES];
    assign bus.r         = r_q;
    assign vld_pipe      = {vld_q, bus.in_valid};
    assign opnd          = {bus.b, bus.a};

    // Unsigned negation maps -2^(N-1) onto 2^(N-1), which still fits N bits.
    always_comb begin
        mag = opnd;
        for (int g = 0; g < 2; g++)
            if (bus.is_signed && opnd[g][N-1]) mag[g] = -opnd[g];
    end

    generate
        for (genvar g = 0; g < 2; g++) begin : g_opnd
            loba_seg #(.N(N), .K(K), .KW(KW)) u_seg (
                .v  (mag[g]),
                .hi (hi_d[g]),
                .lo (lo_d[g]),
                .kh (kh_d[g]),
                .kl (kl_d[g])
            );
        end
    endgenerate

    always_comb begin
        s1_d.hi   = hi_d;
        s1_d.lo   = lo_d;
        s1_d.kh   = kh_d;
        s1_d.kl   = kl_d;
        s1_d.sign = bus.is_signed & (bus.a[N-1] ^ bus.b[N-1]);
        s1_d.mode = bus.mode;
    end

    // Segment positions are clamped to >= K-1, so the shift is never negative.
    function automatic logic [W-1:0] pp(input logic [K-1:0] x, input logic [K-1:0] y,
                                        input logic [KW-1:0] kx, input logic [KW-1:0] ky);
        logic [SHW-1:0] sh;
        sh = SHW'(kx) + SHW'(ky) - SHW'(2 * (K - 1));
        pp = (W'(x) * W'(y)) << sh;
    endfunction

    always_comb begin
        s2_d.pp[0] = pp(s1_q.hi[0], s1_q.hi[1], s1_q.kh[0], s1_q.kh[1]);
        s2_d.pp[1] = pp(s1_q.hi[0], s1_q.lo[1], s1_q.kh[0], s1_q.kl[1]);
        s2_d.pp[2] = pp(s1_q.lo[0], s1_q.hi[1], s1_q.kl[0], s1_q.kh[1]);
        s2_d.pp[3] = pp(s1_q.lo[0], s1_q.lo[1], s1_q.kl[0], s1_q.kl[1]);
        s2_d.sign  = s1_q.sign;
        s2_d.mode  = s1_q.mode;
    end

    always_comb begin
        sum = s2_q.pp[0];
        if (s2_q.mode >= 2'd1) sum = sum + s2_q.pp[1];
        if (s2_q.mode >= 2'd2) sum = sum + s2_q.pp[2];
        if (s2_q.mode == 2'd3) sum = sum + s2_q.pp[3];
        r_d = s2_q.sign ? -sum : sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            s1_q  <= '0;
            s2_q  <= '0;
            r_q   <= '0;
        end else if (en) begin
            vld_q <= vld_pipe[STAGES-1:0];
            s1_q  <= s1_d;
            s2_q  <= s2_d;
            r_q   <= r_d;
        end
    end
endmodule

// File: tb/tb_loba_pipe_mult.sv
// Directed bench for loba_pipe_mult (N=16, K=4): latency, modes, sign, throughput, stall, reset.
module tb_loba_pipe_mult;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    loba_pipe_mult_if #(.N(16)) bus ();

    loba_pipe_mult #(.N(16), .K(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [15:0] a, input logic [15:0] b,
                         input logic [1:0] m, input logic s);
        bus.in_valid  = 1'b1;
        bus.a         = a;
        bus.b         = b;
        bus.mode      = m;
        bus.is_signed = s;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    // One isolated transaction: result must appear exactly 3 cycles after accept.
    task automatic single(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [1:0] m, input logic s, input logic [31:0] exp);
        @(negedge clk);
        drive(a, b, m, s);
        chk({tag, "_rdy"}, 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        idle();
        chk({tag, "_lat1"}, 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        chk({tag, "_lat2"}, 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        chk({tag, "_vld"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_r"}, bus.r, exp);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.mode      = '0;
        bus.is_signed = 1'b0;
        bus.out_ready = 1'b1;

        #12;
        chk("rst_vld", 32'(bus.out_valid), 32'd0);
        chk("rst_r", bus.r, 32'd0);
        chk("rst_rdy", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        single("u_m0", 16'd200, 16'd100, 2'd0, 1'b0, 32'd18432);
        single("u_m1", 16'd200, 16'd100, 2'd1, 1'b0, 32'd19200);
        single("u_m2", 16'd200, 16'd100, 2'd2, 1'b0, 32'd19968);
        single("u_m3", 16'd200, 16'd100, 2'd3, 1'b0, 32'd20000);
        single("s_neg", 16'hFF38, 16'd100, 2'd3, 1'b1, 32'hFFFFB1E0);
        single("u_big", 16'hFF38, 16'd100, 2'd3, 1'b0, 32'd6528000);
        single("s_negneg", 16'hFF38, 16'hFF9C, 2'd3, 1'b1, 32'd20000);
        single("clamp", 16'd5, 16'd7, 2'd0, 1'b0, 32'd35);
        single("zero", 16'd0, 16'h8000, 2'd3, 1'b1, 32'd0);
        single("minint", 16'h8000, 16'd1, 2'd3, 1'b1, 32'hFFFF8000);

        // Back-to-back: small operands make mode 3 exact.
        for (int k = 0; k <= 11; k++) begin
            @(negedge clk);
            if (k < 8) drive(16'(k * 17 + 3), 16'(k * 11 + 5), 2'd3, 1'b0);
            else       idle();
            if (k >= 3 && k <= 10) begin
                chk("b2b_vld", 32'(bus.out_valid), 32'd1);
                chk("b2b_r", bus.r, 32'(((k - 3) * 17 + 3) * ((k - 3) * 11 + 5)));
            end
            if (k == 11) chk("b2b_end", 32'(bus.out_valid), 32'd0);
        end

        // Stall: three in flight, a fourth waiting while out_ready is low.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive(16'(k + 2), 16'd9, 2'd3, 1'b0);
        end
        @(negedge clk);
        drive(16'd5, 16'd9, 2'd3, 1'b0);
        bus.out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            if (s > 0) @(negedge clk);
            #1;
            chk("stall_rdy", 32'(bus.in_ready), 32'd0);
            chk("stall_vld", 32'(bus.out_valid), 32'd1);
            chk("stall_r", bus.r, 32'd18);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        #1;
        chk("rel_rdy", 32'(bus.in_ready), 32'd1);
        chk("rel_r0", bus.r, 32'd18);
        @(negedge clk);
        idle();
        chk("rel_r1", bus.r, 32'd27);
        @(negedge clk);
        chk("rel_r2", bus.r, 32'd36);
        @(negedge clk);
        chk("rel_r3", bus.r, 32'd45);
        chk("rel_v3", 32'(bus.out_valid), 32'd1);
        @(negedge clk);
        chk("rel_end", 32'(bus.out_valid), 32'd0);

        // Reset with three transactions in flight.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive(16'd3, 16'(k + 1), 2'd3, 1'b0);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        idle();
        #1;
        chk("mrst_vld", 32'(bus.out_valid), 32'd0);
        chk("mrst_r", bus.r, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("post_rst_vld", 32'(bus.out_valid), 32'd0);
        end
        chk("post_rst_rdy", 32'(bus.in_ready), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
